// File: rtl/clk_div_chk_pkg.sv
// Shared types and constants for the divided-clock checker.
//   state_e        : checker FSM states
//   LockCntDefault : default number of consecutive good periods needed for lock
//   ErrCntW        : width of the saturating error counter
//   period_good()  : good-period test for a measured period/high time against N
package clk_div_chk_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAcq,
    StMeas,
    StLock
  } state_e;

  localparam int unsigned LockCntDefault = 4;
  localparam int unsigned ErrCntW        = 8;

  // Period must equal N exactly; high time may be floor(N/2) or ceil(N/2), so odd ratios
  // with either duty rounding are accepted.
  function automatic logic period_good(logic [31:0] period, logic [31:0] high, logic [3:0] n);
    logic [31:0] n32;
    logic [31:0] half_lo;
    logic [31:0] half_hi;
    n32     = 32'(n);
    half_lo = n32 >> 1;
    half_hi = (n32 + 32'd1) >> 1;
    return (period == n32) && ((high == half_lo) || (high == half_hi));
  endfunction

endpackage

// File: rtl/clk_div_chk_sync.sv
// Synchronizer and rising-edge detector for the divided clock under test.
// The divided clock is treated purely as data sampled on i_clk.
//   i_clk   : sampling clock (rising edge)
//   i_rst   : synchronous active-high reset, clears all flops
//   i_d     : asynchronous divided clock input
//   o_level : synchronized level (last synchronizer stage)
//   o_rise  : 1-cycle pulse when the synchronized level goes 0 -> 1
module clk_div_chk_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_level,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_d};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign o_level = sync_q[SYNC_STAGES-1];
  assign o_rise  = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

// File: rtl/clk_div_chk.sv
// Divided-clock checker: measures the period and high time of i_clk_div in i_clk cycles,
// compares them against the expected divide ratio and reports lock / error status.
//   i_clk     : single clock, rising edge
//   i_rst     : synchronous active-high reset
//   i_en      : checker enable; low returns to idle and clears lock state
//   i_div_n   : expected divide ratio (2..15), captured when leaving idle
//   i_clk_div : divided clock under test (sampled as data)
//   o_lock    : locked after LOCK_CNT consecutive good periods
//   o_valid   : 1-cycle pulse when a period measurement completes
//   o_period  : last measured period
//   o_high    : last measured high time
//   o_err     : 1-cycle pulse on a bad period or timeout
//   o_err_cnt : saturating error count, cleared by reset or falling i_en
module clk_div_chk
  import clk_div_chk_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_CNT    = LockCntDefault,
  parameter int unsigned CNT_W       = 5
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic [3:0]         i_div_n,
  input  logic               i_clk_div,
  output logic               o_lock,
  output logic               o_valid,
  output logic [CNT_W-1:0]   o_period,
  output logic [CNT_W-1:0]   o_high,
  output logic               o_err,
  output logic [ErrCntW-1:0] o_err_cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic sync_level;
  logic sync_rise;

  clk_div_chk_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_d    (i_clk_div),
    .o_level(sync_level),
    .o_rise (sync_rise)
  );

  state_e               state_q, state_d;
  logic [3:0]           div_n_q, div_n_d;
  logic [CNT_W-1:0]     period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0]     high_cnt_q, high_cnt_d;
  logic [3:0]           good_cnt_q, good_cnt_d;
  logic                 lock_q, lock_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic [CNT_W-1:0]     period_q, period_d;
  logic [CNT_W-1:0]     high_q, high_d;
  logic [ErrCntW-1:0]   err_cnt_q, err_cnt_d;
  logic                 en_q;

  logic [CNT_W-1:0]     period_inc;
  logic [CNT_W-1:0]     high_inc;
  logic                 timeout;
  logic                 good;

  // Counters saturate rather than wrap; reaching the saturated value also counts as a
  // timeout, which covers widths too narrow to hold 2*N+2.
  always_comb begin
    period_inc = (period_cnt_q == CntMax) ? CntMax : period_cnt_q + 1'b1;
    high_inc   = (high_cnt_q == CntMax) ? CntMax : high_cnt_q + 1'b1;
    timeout    = (32'(period_cnt_q) >= ((32'(div_n_q) << 1) + 32'd2)) ||
                 (period_cnt_q == CntMax);
    good       = period_good(32'(period_cnt_q), 32'(high_cnt_q), div_n_q);
  end

  always_comb begin
    state_d      = state_q;
    div_n_d      = div_n_q;
    period_cnt_d = period_cnt_q;
    high_cnt_d   = high_cnt_q;
    good_cnt_d   = good_cnt_q;
    lock_d       = lock_q;
    valid_d      = 1'b0;
    err_d        = 1'b0;
    period_d     = period_q;
    high_d       = high_q;
    err_cnt_d    = err_cnt_q;

    if (!i_en) begin
      // Disable wins over any edge or timeout in the same cycle.
      state_d      = StIdle;
      period_cnt_d = '0;
      high_cnt_d   = '0;
      good_cnt_d   = '0;
      lock_d       = 1'b0;
      if (en_q) begin
        err_cnt_d = '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          period_cnt_d = '0;
          high_cnt_d   = '0;
          good_cnt_d   = '0;
          lock_d       = 1'b0;
          if (i_div_n >= 4'd2) begin
            div_n_d = i_div_n;
            state_d = StAcq;
          end
        end

        StAcq: begin
          // Acquisition edge only aligns the counters. The edge cycle itself is counted
          // (load 1) so the count at the next edge equals the edge-to-edge distance.
          if (sync_rise) begin
            period_cnt_d = CNT_W'(1);
            high_cnt_d   = CNT_W'(1);
            state_d      = StMeas;
          end else if (timeout) begin
            // Keep re-arming so a stuck input reports repeatedly.
            err_d        = 1'b1;
            period_cnt_d = '0;
          end else begin
            period_cnt_d = period_inc;
          end
        end

        StMeas, StLock: begin
          if (sync_rise) begin
            valid_d      = 1'b1;
            period_d     = period_cnt_q;
            high_d       = high_cnt_q;
            period_cnt_d = CNT_W'(1);
            high_cnt_d   = CNT_W'(1);
            if (good) begin
              if ((32'(good_cnt_q) + 32'd1) >= LOCK_CNT) begin
                good_cnt_d = 4'(LOCK_CNT);
                lock_d     = 1'b1;
                state_d    = StLock;
              end else begin
                good_cnt_d = good_cnt_q + 4'd1;
              end
            end else begin
              err_d      = 1'b1;
              good_cnt_d = '0;
              lock_d     = 1'b0;
              state_d    = StMeas;
            end
          end else if (timeout) begin
            err_d        = 1'b1;
            lock_d       = 1'b0;
            good_cnt_d   = '0;
            period_cnt_d = '0;
            high_cnt_d   = '0;
            state_d      = StAcq;
          end else begin
            period_cnt_d = period_inc;
            if (sync_level) begin
              high_cnt_d = high_inc;
            end
          end
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end

    if (err_d && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= StIdle;
      div_n_q      <= '0;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      good_cnt_q   <= '0;
      lock_q       <= 1'b0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      period_q     <= '0;
      high_q       <= '0;
      err_cnt_q    <= '0;
      en_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_n_q      <= div_n_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      good_cnt_q   <= good_cnt_d;
      lock_q       <= lock_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      period_q     <= period_d;
      high_q       <= high_d;
      err_cnt_q    <= err_cnt_d;
      en_q         <= i_en;
    end
  end

  assign o_lock    = lock_q;
  assign o_valid   = valid_q;
  assign o_period  = period_q;
  assign o_high    = high_q;
  assign o_err     = err_q;
  assign o_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_clk_div_chk.sv
// Self-checking bench for clk_div_chk: expected measurements are pushed when a period is
// driven and popped/compared when o_valid pulses.
module tb_clk_div_chk;

  localparam int LockCnt = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] div_n;
  logic       clk_div;
  logic       o_lock;
  logic       o_valid;
  logic [4:0] o_period;
  logic [4:0] o_high;
  logic       o_err;
  logic [7:0] o_err_cnt;

  clk_div_chk u_dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_en     (en),
    .i_div_n  (div_n),
    .i_clk_div(clk_div),
    .o_lock   (o_lock),
    .o_valid  (o_valid),
    .o_period (o_period),
    .o_high   (o_high),
    .o_err    (o_err),
    .o_err_cnt(o_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int period;
    int high;
    int lock;
    int err;
    int err_cnt;
  } exp_t;

  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int valid_seen = 0;
  int last_valid_cyc = 0;
  bit gap_arm = 1'b0;

  // Reference model state
  int m_n;
  int m_good;
  int m_errcnt;
  bit have_prev;
  int prev_p;
  int prev_h;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Score the previously driven period against the captured ratio.
  task automatic push_prev();
    exp_t e;
    bit   g;
    g = (prev_p == m_n) && ((prev_h == m_n / 2) || (prev_h == (m_n + 1) / 2));
    if (g) begin
      if (m_good < LockCnt) m_good++;
    end else begin
      m_good = 0;
      if (m_errcnt < 255) m_errcnt++;
    end
    e.period  = prev_p;
    e.high    = prev_h;
    e.lock    = (m_good >= LockCnt) ? 1 : 0;
    e.err     = g ? 0 : 1;
    e.err_cnt = m_errcnt;
    sb_q.push_back(e);
  endtask

  task automatic seg(input int p, input int h);
    if (have_prev) push_prev();
    for (int i = 0; i < p; i++) begin
      clk_div = (i < h);
      tick();
    end
    have_prev = 1'b1;
    prev_p    = p;
    prev_h    = h;
  endtask

  task automatic start_scen(input int n);
    en      = 1'b0;
    clk_div = 1'b0;
    repeat (6) tick();
    div_n     = 4'(n);
    m_n       = n;
    m_good    = 0;
    m_errcnt  = 0;
    have_prev = 1'b0;
    gap_arm   = 1'b0;
    en        = 1'b1;
  endtask

  // Close the last period with one more rising edge, then let the scoreboard drain.
  task automatic end_scen();
    if (have_prev) begin
      push_prev();
      clk_div = 1'b1;
      tick();
      clk_div   = 1'b0;
      have_prev = 1'b0;
    end
    repeat (5) tick();
    chk("sb_drained", sb_q.size(), 0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Monitor: compare each completed measurement against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && o_valid) begin
        valid_seen++;
        chk("sb_nonempty_on_valid", (sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk("period", o_period, e.period);
          chk("high", o_high, e.high);
          chk("lock_at_valid", o_lock, e.lock);
          chk("err_at_valid", o_err, e.err);
          chk("err_cnt_at_valid", o_err_cnt, e.err_cnt);
          if (gap_arm) chk("valid_gap", cyc - last_valid_cyc, e.period);
          gap_arm        = 1'b1;
          last_valid_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int v0;

    rst     = 1'b1;
    en      = 1'b0;
    div_n   = 4'd0;
    clk_div = 1'b0;
    repeat (3) tick();
    chk("rst_lock", o_lock, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_err", o_err, 0);
    chk("rst_period", o_period, 0);
    chk("rst_high", o_high, 0);
    chk("rst_err_cnt", o_err_cnt, 0);
    rst = 1'b0;
    tick();

    // N=3 with mixed 1/2-sample high times; lock on the 4th measurement
    start_scen(3);
    for (int i = 0; i < 3; i++) begin
      seg(3, 1);
      seg(3, 2);
    end
    chk("n3_locked", o_lock, 1);
    // One period of 4 breaks lock, then four good periods relock
    seg(4, 2);
    repeat (5) seg(3, 1);
    end_scen();
    chk("n3_relocked", o_lock, 1);
    chk("n3_err_cnt", o_err_cnt, 1);

    // N=4 at 50% duty
    start_scen(4);
    repeat (6) seg(4, 2);
    end_scen();
    chk("n4_locked", o_lock, 1);
    chk("n4_err_cnt", o_err_cnt, 0);
    chk("n4_period", o_period, 4);
    chk("n4_high", o_high, 2);

    // Ratio change while locked is ignored; re-enable picks up N=6
    start_scen(3);
    repeat (6) seg(3, 1);
    div_n = 4'd6;
    repeat (3) seg(3, 1);
    end_scen();
    chk("ratio_change_ignored_lock", o_lock, 1);
    chk("ratio_change_ignored_err", o_err_cnt, 0);
    start_scen(6);
    repeat (6) seg(6, 3);
    end_scen();
    chk("n6_locked", o_lock, 1);
    chk("n6_period", o_period, 6);

    // Stuck-low input with N=5: timeout at count 2*5+2, repeating every 13 cycles
    start_scen(5);
    k = 0;
    do begin
      tick();
      k++;
    end while (!o_err && k < 40);
    chk("timeout_first_latency", k, 14);
    k = 0;
    do begin
      tick();
      k++;
    end while (!o_err && k < 40);
    chk("timeout_repeat_gap", k, 13);
    chk("timeout_err_cnt", o_err_cnt, 2);
    chk("timeout_lock", o_lock, 0);
    end_scen();

    // Ratio below 2 keeps the block idle
    start_scen(1);
    v0 = valid_seen;
    repeat (6) begin
      clk_div = 1'b1;
      tick();
      clk_div = 1'b0;
      tick();
      tick();
    end
    repeat (4) tick();
    chk("n1_no_valid", valid_seen - v0, 0);
    chk("n1_no_err", o_err_cnt, 0);
    chk("n1_no_lock", o_lock, 0);

    // Reset while locked clears everything; full acquisition needed again
    start_scen(3);
    repeat (6) seg(3, 1);
    repeat (2) tick();
    chk("pre_rst_lock", o_lock, 1);
    chk("pre_rst_sb", sb_q.size(), 0);
    rst     = 1'b1;
    clk_div = 1'b0;
    tick();
    chk("mid_rst_lock", o_lock, 0);
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_err", o_err, 0);
    chk("mid_rst_period", o_period, 0);
    chk("mid_rst_high", o_high, 0);
    chk("mid_rst_err_cnt", o_err_cnt, 0);
    sb_q.delete();
    have_prev = 1'b0;
    m_good    = 0;
    m_errcnt  = 0;
    gap_arm   = 1'b0;
    rst       = 1'b0;
    seg(3, 2);
    seg(3, 2);
    seg(3, 2);
    seg(3, 2);
    chk("post_rst_not_yet_locked", o_lock, 0);
    seg(3, 2);
    end_scen();
    chk("post_rst_relocked", o_lock, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
